shift_exec_pipe: RTL and testbench
==================================

SHIFT_EXEC_PIPE -- requirements
Module: shift_exec_pipe

Interface
REQ-001 Parameter RD_W, default 3, is the destination-register tag width.
REQ-002 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, is the reset; synchronous, active-high.
REQ-004 Port in_valid, input, 1, means a shift op is offered.
REQ-005 Port in_ready, output, 1, means the pipe accepts the offered op this cycle.
REQ-006 Port in_data, input, 16, is the operand.
REQ-007 Port in_cnt, input, 4, is the shift/rotate amount, 0-15.
REQ-008 Port in_op, input, 2, is the operation: 00 rotate-left, 01 shift-left-logical, 10 shift-right-arithmetic, 11 shift-right-logical.
REQ-009 Port in_rd, input, RD_W, is the destination tag carried alongside the data.
REQ-010 Port flush, input, 1, kills all in-flight ops.
REQ-011 Port out_valid, output, 1, means a result is presented.
REQ-012 Port out_ready, input, 1, means downstream consumes the result this cycle.
REQ-013 Port out_data, output, 16, is the registered shift result.
REQ-014 Port out_rd, output, RD_W, is the tag of out_data.
REQ-015 Port perf_done, output, 16, is present only with SHIFT_PERF_EN and counts completed results.
REQ-016 Port perf_stall, output, 16, is present only with SHIFT_PERF_EN and counts backpressure cycles.

Function
REQ-017 Two register stages: S1 holds operand/cnt/op/rd; S2 holds the shifter result and rd.
REQ-018 The combinational shifter sits between S1 and S2; out_data/out_rd come directly from S2 registers.
REQ-019 s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv && !flush.
REQ-020 An input is accepted on in_valid && in_ready; S1 loads and s1_valid sets.
REQ-021 S2 loads from S1 when s1_valid && s2_adv; s1_valid clears if no new accept that cycle.
REQ-022 Latency: an accepted op appears on out_valid exactly 2 cycles later with out_ready high; throughput is 1 op/cycle.
REQ-023 With out_valid high and out_ready low, S2 contents SHALL hold unchanged; S1 holds while S2 is full.
REQ-024 Ops SHALL emerge in acceptance order; none dropped or duplicated except by flush/rst.
REQ-025 flush clears s1_valid and s2_valid next edge, dominating a simultaneous accept or advance; data registers may keep stale values.
REQ-026 in_cnt 0 passes in_data unchanged for all ops.
REQ-027 Shift-right-arithmetic replicates bit 15; logical shifts fill with 0; rotate wraps bits from 15 to 0.
REQ-028 out_valid SHALL never be high in the cycle after flush or rst.

Reset
REQ-029 rst sets s1_valid, s2_valid, out_data, out_rd to 0, and in_ready to 1 on the cycle after rst deasserts.
REQ-030 rst mid-operation discards all in-flight ops; no output handshake occurs for them.
REQ-031 perf counters reset to 0.

Configuration
REQ-032 Macro SHIFT_PERF_EN defined: perf_done increments on out_valid && out_ready, and perf_stall increments on out_valid && !out_ready; both saturate at 16'hFFFF, with no wrap.
REQ-033 Macro SHIFT_PERF_EN undefined: perf ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-034 Shared package/header holds the op encodings (OP_ROL, OP_SLL, OP_SRA, OP_SRL), the data width 16 and the count width 4.
REQ-035 One sub-module: the existing barrel shifter shift_rotate (In, Cnt, Op, Out), instantiated once between S1 and S2.

Verification
REQ-036 The bench SHALL cover the following directed scenarios.
- Basic op: in_data=16'h8001, cnt=1, op=01, out_ready=1 -> out_data=16'h0002 exactly 2 cycles after accept.
- Rotate and sign: ROL 16'h8001 cnt 4 -> 16'h0018; SRA 16'h8000 cnt 15 -> 16'hFFFF; SRL 16'h8000 cnt 15 -> 16'h0001; cnt 0 -> passthrough.
- Backpressure: 4 back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts, S2 stays stable; then out_ready=1 -> all 4 results emerge in order with correct rd.
- Flush: flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, input not accepted, following op emerges normally.
- Reset: rst asserted mid-stream -> all valids 0 and out_data=0; no stale result emerges after release.
- SHIFT_PERF_EN: 3 completions plus 5 stall cycles -> perf_done=3 and perf_stall=5; forced 16'hFFFF stays 16'hFFFF on a further event.

Source files
------------

// File: rtl/shift_exec_pipe_pkg.sv
// Shared definitions for the shift execution pipe.
// Holds the datapath/count widths and the operation encodings used by the
// pipeline top (shift_exec_pipe) and the barrel shifter (shift_rotate).
package shift_exec_pipe_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_SRA = 2'b10,
      OP_SRL = 2'b11
   } shift_op_e;

endpackage

// File: rtl/shift_rotate.sv
// Combinational 16-bit barrel shifter / rotator.
// Ports:
//   In  - operand
//   Cnt - shift/rotate amount, 0-15 (0 passes In through for every op)
//   Op  - OP_ROL / OP_SLL / OP_SRA / OP_SRL
//   Out - result
module shift_rotate
   import shift_exec_pipe_pkg::*;
(
   input  logic [DATA_W-1:0] In,
   input  logic [CNT_W-1:0]  Cnt,
   input  shift_op_e         Op,
   output logic [DATA_W-1:0] Out
);

   logic [2*DATA_W-1:0] rol_w;

   always_comb begin
      // Rotating the doubled word left leaves the wrapped result in the top half.
      rol_w = {In, In} << Cnt;
      Out   = In;
      case (Op)
         OP_ROL:  Out = rol_w[2*DATA_W-1:DATA_W];
         OP_SLL:  Out = In << Cnt;
         OP_SRA:  Out = $unsigned($signed(In) >>> Cnt);
         OP_SRL:  Out = In >> Cnt;
         default: Out = In;
      endcase
   end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage shift execution pipe with valid/ready handshakes on both sides.
// S1 registers the offered op; shift_rotate computes between S1 and S2; S2
// registers the result, which drives out_data/out_rd directly.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; in_data, in_cnt, in_op, in_rd
//   flush               - kills every in-flight op on the next edge
//   out_valid/out_ready - output handshake; out_data, out_rd
//   perf_done/perf_stall - saturating completion / backpressure counters,
//                         present only when SHIFT_PERF_EN is defined
module shift_exec_pipe
   import shift_exec_pipe_pkg::*;
#(
   parameter int RD_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_cnt,
   input  logic [1:0]        in_op,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd
`ifdef SHIFT_PERF_EN
   ,
   output logic [15:0]       perf_done,
   output logic [15:0]       perf_stall
`endif
);

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [CNT_W-1:0]  s1_cnt_q,   s1_cnt_d;
   shift_op_e         s1_op_q,    s1_op_d;
   logic [RD_W-1:0]   s1_rd_q,    s1_rd_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic [RD_W-1:0]   s2_rd_q,    s2_rd_d;

   logic              s2_adv, s1_adv, accept, s1_to_s2;
   logic [DATA_W-1:0] shift_res;

   shift_rotate u_shift (
      .In  (s1_data_q),
      .Cnt (s1_cnt_q),
      .Op  (s1_op_q),
      .Out (shift_res)
   );

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign accept   = in_valid && in_ready;
   assign s1_to_s2 = s1_valid_q && s2_adv;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_cnt_d   = s1_cnt_q;
      s1_op_d    = s1_op_q;
      s1_rd_d    = s1_rd_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_rd_d    = s2_rd_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = in_data;
         s1_cnt_d   = in_cnt;
         s1_op_d    = shift_op_e'(in_op);
         s1_rd_d    = in_rd;
      end else if (s1_to_s2) begin
         s1_valid_d = 1'b0;
      end

      // When S2 may advance it either takes S1 or empties.
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_to_s2) begin
         s2_data_d = shift_res;
         s2_rd_d   = s1_rd_q;
      end

      // Data registers may pick up stale values here; only the valids matter.
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_cnt_q   <= '0;
         s1_op_q    <= OP_ROL;
         s1_rd_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_rd_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_cnt_q   <= s1_cnt_d;
         s1_op_q    <= s1_op_d;
         s1_rd_q    <= s1_rd_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_rd_q    <= s2_rd_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_rd    = s2_rd_q;

`ifdef SHIFT_PERF_EN
   logic [15:0] perf_done_q,  perf_done_d;
   logic [15:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_done_d  = perf_done_q;
      perf_stall_d = perf_stall_q;
      if (s2_valid_q && out_ready && (perf_done_q != 16'hFFFF)) begin
         perf_done_d = perf_done_q + 16'd1;
      end
      if (s2_valid_q && !out_ready && (perf_stall_q != 16'hFFFF)) begin
         perf_stall_d = perf_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_done_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_done_q  <= perf_done_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_done  = perf_done_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: table of directed shift vectors,
// a random stream with random backpressure, and hand-written sequences for
// latency, backpressure, flush, reset and (with SHIFT_PERF_EN) the counters.
module tb_shift_exec_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_cnt;
   logic [1:0]  in_op;
   logic [2:0]  in_rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_rd;
`ifdef SHIFT_PERF_EN
   logic [15:0] perf_done;
   logic [15:0] perf_stall;
`endif

   shift_exec_pipe #(.RD_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cnt    (in_cnt),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd)
`ifdef SHIFT_PERF_EN
      ,
      .perf_done (perf_done),
      .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  c;
      logic [1:0]  op;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  rd;
      int          cyc;
      bit          lat;
   } sb_t;

   vec_t        vt[15];
   sb_t         sbq[$];
   sb_t         e;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [15:0] cur_exp = '0;
   bit          cur_lat = 1'b0;
   bit          rand_bp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] c,
                                         input logic [1:0] op);
      logic [15:0] r;
      r = d;
      for (int i = 0; i < int'(c); i++) begin
         case (op)
            2'b00:   r = {r[14:0], r[15]};
            2'b01:   r = {r[14:0], 1'b0};
            2'b10:   r = {r[15], r[15:1]};
            default: r = {1'b0, r[15:1]};
         endcase
      end
      return r;
   endfunction

   // Scoreboard: handshakes are observed on the falling edge, ahead of the
   // rising edge where they take effect.
   always @(negedge clk) begin
      cyc++;
      if (rst || flush) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out: got data %h rd %0d, expected no output", out_data, out_rd);
            end else begin
               e = sbq.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_rd", 32'(out_rd), 32'(e.rd));
               if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
         end
         if (in_valid && in_ready) sbq.push_back('{cur_exp, in_rd, cyc, cur_lat});
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                       input logic [2:0] rd, input logic [15:0] exp, input bit lat = 1'b0);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_cnt   = c;
      in_op    = op;
      in_rd    = rd;
      cur_exp  = exp;
      cur_lat  = lat;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         acc = in_ready;
         step();
         if (acc) break;
      end
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      in_valid = 1'b0;
      cur_lat  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (sbq.size() == 0) break;
         step();
      end
      if (sbq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] rd_d;
      logic [3:0]  rd_c;
      logic [1:0]  rd_op;

      vt[0]  = '{16'h8001, 4'd1,  2'b01, 16'h0002};
      vt[1]  = '{16'h8001, 4'd4,  2'b00, 16'h0018};
      vt[2]  = '{16'h8000, 4'd15, 2'b10, 16'hFFFF};
      vt[3]  = '{16'h8000, 4'd15, 2'b11, 16'h0001};
      vt[4]  = '{16'h1234, 4'd0,  2'b00, 16'h1234};
      vt[5]  = '{16'h1234, 4'd0,  2'b01, 16'h1234};
      vt[6]  = '{16'h8234, 4'd0,  2'b10, 16'h8234};
      vt[7]  = '{16'h1234, 4'd0,  2'b11, 16'h1234};
      vt[8]  = '{16'h1234, 4'd4,  2'b00, 16'h2341};
      vt[9]  = '{16'h1234, 4'd4,  2'b11, 16'h0123};
      vt[10] = '{16'hF0F0, 4'd4,  2'b10, 16'hFF0F};
      vt[11] = '{16'h70F0, 4'd4,  2'b10, 16'h070F};
      vt[12] = '{16'h0001, 4'd15, 2'b01, 16'h8000};
      vt[13] = '{16'h8001, 4'd15, 2'b00, 16'hC000};
      vt[14] = '{16'hABCD, 4'd8,  2'b00, 16'hCDAB};

      in_valid  = 1'b0;
      in_data   = '0;
      in_cnt    = '0;
      in_op     = '0;
      in_rd     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      do_reset();

      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      step();

      // Basic op with latency check on an empty pipe.
      out_ready = 1'b1;
      send(16'h8001, 4'd1, 2'b01, 3'd5, 16'h0002, 1'b1);
      drain();

      // Table, back to back with out_ready held high.
      for (int i = 0; i < 15; i++) send(vt[i].d, vt[i].c, vt[i].op, 3'(i), vt[i].exp);
      drain();

      // Random stream under random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 24; i++) begin
         rd_d  = 16'($urandom);
         rd_c  = 4'($urandom_range(0, 15));
         rd_op = 2'($urandom_range(0, 3));
         send(rd_d, rd_c, rd_op, 3'(i), model(rd_d, rd_c, rd_op));
         if ($urandom_range(0, 3) == 0) step();
      end
      rand_bp = 1'b0;
      step();
      out_ready = 1'b1;
      drain();

      // Backpressure: two accepts fill the pipe, the third offer stalls.
      out_ready = 1'b0;
      send(16'h1111, 4'd1, 2'b01, 3'd4, 16'h2222);
      send(16'h8000, 4'd1, 2'b10, 3'd5, 16'hC000);
      in_valid = 1'b1;
      in_data  = 16'h00F0;
      in_cnt   = 4'd4;
      in_op    = 2'b11;
      in_rd    = 3'd6;
      cur_exp  = 16'h000F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_s2_data", 32'(out_data), 32'h2222);
         chk("bp_s2_rd", 32'(out_rd), 32'd4);
         step();
      end
      out_ready = 1'b1;
      send(16'h00F0, 4'd4, 2'b11, 3'd6, 16'h000F);
      send(16'h1234, 4'd8, 2'b00, 3'd7, 16'h3412);
      drain();

      // Flush with both stages full and a new op offered.
      out_ready = 1'b0;
      send(16'h0003, 4'd1, 2'b01, 3'd1, 16'h0006);
      send(16'h0005, 4'd1, 2'b01, 3'd2, 16'h000A);
      in_valid = 1'b1;
      in_data  = 16'h0007;
      in_cnt   = 4'd1;
      in_op    = 2'b01;
      in_rd    = 3'd3;
      cur_exp  = 16'h000E;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      step();
      out_ready = 1'b1;
      send(16'h4001, 4'd2, 2'b00, 3'd3, 16'h0005);
      drain();
      repeat (3) step();

      // Reset mid-stream.
      out_ready = 1'b0;
      send(16'h00FF, 4'd4, 2'b01, 3'd1, 16'h0FF0);
      send(16'h0F00, 4'd4, 2'b11, 3'd2, 16'h00F0);
      in_valid = 1'b1;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      step();
      out_ready = 1'b1;
      repeat (5) step();
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      step();

`ifdef SHIFT_PERF_EN
      do_reset();
      @(negedge clk);
      chk("perf_done_rst", 32'(perf_done), 32'd0);
      chk("perf_stall_rst", 32'(perf_stall), 32'd0);
      step();
      out_ready = 1'b0;
      send(16'h0001, 4'd1, 2'b01, 3'd1, 16'h0002);
      step();
      repeat (5) step();
      out_ready = 1'b1;
      send(16'h0001, 4'd2, 2'b01, 3'd2, 16'h0004);
      send(16'h0001, 4'd3, 2'b01, 3'd3, 16'h0008);
      drain();
      repeat (2) step();
      @(negedge clk);
      chk("perf_done", 32'(perf_done), 32'd3);
      chk("perf_stall", 32'(perf_stall), 32'd5);
      step();

      out_ready = 1'b0;
      send(16'h0001, 4'd4, 2'b01, 3'd4, 16'h0010);
      step();
      force dut.perf_stall_q = 16'hFFFF;
      force dut.perf_done_q  = 16'hFFFF;
      @(negedge clk);
      release dut.perf_stall_q;
      release dut.perf_done_q;
      step();
      @(negedge clk);
      chk("perf_stall_sat", 32'(perf_stall), 32'hFFFF);
      step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("perf_done_sat", 32'(perf_done), 32'hFFFF);
      step();
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
